// File: rtl/servo_sequencer.sv
// servo_sequencer: eight-channel hobby-servo pulse sequencer.
// A 20 ms frame is split into eight 2.5 ms slots. Slot k carries channel k's
// pulse, 1000..2000 us wide. Pulse widths are written into shadow registers
// at any time. They are copied to the active set only at a frame commit, so a
// frame in progress never changes.
module servo_sequencer #(
  parameter int unsigned SYS_CLK = 50000000,
  parameter int unsigned NUM_CH  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [NUM_CH-1:0] ch_en,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [2:0]        wr_addr,
  input  logic [15:0]       wr_data,
  output logic [NUM_CH-1:0] servo,
  output logic              frame_sync,
  output logic [2:0]        active_ch
);

  localparam int unsigned CLKS_PER_US = SYS_CLK / 1000000;
  localparam int unsigned DIV_W       = (CLKS_PER_US > 1) ? $clog2(CLKS_PER_US) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKS_PER_US - 1);

  localparam logic [11:0] SLOT_LAST = 12'd2499;
  localparam logic [2:0]  CH_LAST   = 3'd7;

  localparam logic [10:0] PW_MIN   = 11'd1000;
  localparam logic [10:0] PW_MAX   = 11'd2000;
  localparam logic [10:0] PW_RESET = 11'd1500;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;

  logic [1:0]       state;
  logic [DIV_W-1:0] div;
  logic [11:0]      us_cnt;

  logic [DIV_W-1:0] div_nxt;
  logic [11:0]      us_nxt;
  logic [2:0]       ch_nxt;

  logic [10:0] shadow    [NUM_CH];
  logic [10:0] active_pw [NUM_CH];
  logic [10:0] wr_clamped;

  logic              tick;
  logic              slot_end;
  logic              frame_end;
  logic              commit;
  logic              wr_fire;
  logic              running;
  logic [NUM_CH-1:0] servo_nxt;

  // Timebase decode and the frame-commit condition.
  // Commit happens on the IDLE->RUN start and on every 7->0 slot wrap while running.
  always_comb begin
    tick      = (div == DIV_LAST);
    slot_end  = tick && (us_cnt == SLOT_LAST);
    frame_end = slot_end && (active_ch == CH_LAST);
    running   = (state == RUN) || (state == DRAIN);
    commit    = en && ((state == IDLE) || ((state == RUN) && frame_end));
  end

  // Writes stall only on the commit cycle, so a shadow update never races the copy.
  always_comb begin
    wr_ready = rst | ~commit;
    wr_fire  = wr_valid & wr_ready;
  end

  // Clamp incoming pulse widths to the legal servo range.
  always_comb begin
    if (wr_data < 16'(PW_MIN)) begin
      wr_clamped = PW_MIN;
    end else if (wr_data > 16'(PW_MAX)) begin
      wr_clamped = PW_MAX;
    end else begin
      wr_clamped = wr_data[10:0];
    end
  end

  // Next values of the divider / microsecond / slot counters while running.
  always_comb begin
    div_nxt = tick ? '0 : div + DIV_W'(1);
    us_nxt  = us_cnt;
    ch_nxt  = active_ch;
    if (tick) begin
      if (us_cnt == SLOT_LAST) begin
        us_nxt = '0;
        ch_nxt = active_ch + 3'd1;
      end else begin
        us_nxt = us_cnt + 12'd1;
      end
    end
  end

  // Sequencer FSM and timebase counters.
  // en low exactly on a slot's last cycle goes straight to IDLE, since DRAIN
  // would otherwise run a whole extra slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      div       <= '0;
      us_cnt    <= '0;
      active_ch <= '0;
    end else begin
      case (state)
        IDLE: begin
          div       <= '0;
          us_cnt    <= '0;
          active_ch <= '0;
          if (en) begin
            state <= RUN;
          end
        end
        RUN: begin
          if (slot_end && !en) begin
            state     <= IDLE;
            div       <= '0;
            us_cnt    <= '0;
            active_ch <= '0;
          end else begin
            div       <= div_nxt;
            us_cnt    <= us_nxt;
            active_ch <= ch_nxt;
            if (!en) begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (slot_end) begin
            state     <= IDLE;
            div       <= '0;
            us_cnt    <= '0;
            active_ch <= '0;
          end else begin
            div       <= div_nxt;
            us_cnt    <= us_nxt;
            active_ch <= ch_nxt;
          end
        end
        default: begin
          state     <= IDLE;
          div       <= '0;
          us_cnt    <= '0;
          active_ch <= '0;
        end
      endcase
    end
  end

  // Shadow widths take writes. The active widths are reloaded only at a commit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        shadow[i]    <= PW_RESET;
        active_pw[i] <= PW_RESET;
      end
    end else begin
      if (commit) begin
        for (int unsigned i = 0; i < NUM_CH; i++) begin
          active_pw[i] <= shadow[i];
        end
      end
      if (wr_fire) begin
        shadow[wr_addr] <= wr_clamped;
      end
    end
  end

  // Only the slot owner can drive its pulse. ch_en gates it combinationally.
  always_comb begin
    servo_nxt = '0;
    if (running && ch_en[active_ch] && (us_cnt < {1'b0, active_pw[active_ch]})) begin
      servo_nxt[active_ch] = 1'b1;
    end
  end

  // Registered outputs: one clock behind the counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      servo      <= '0;
      frame_sync <= 1'b0;
    end else begin
      servo      <= servo_nxt;
      frame_sync <= commit;
    end
  end

endmodule

// File: doc/servo_sequencer.md
SERVO_SEQUENCER -- requirements
Module: servo_sequencer

Interface
REQ-001 SHALL have parameter SYS_CLK, default 50000000, system clock frequency in Hz; SYS_CLK/1000000 (CLKS_PER_US) integer >= 2.
REQ-002 SHALL have parameter NUM_CH, fixed at 8, number of servo channels.
REQ-003 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port en  input  1  global run enable.
REQ-006 SHALL have port ch_en  input  8  per-channel output enable.
REQ-007 SHALL have port wr_valid  input  1  pulse-width write request.
REQ-008 SHALL have port wr_ready  output  1  write accept; write occurs when wr_valid & wr_ready on a rising edge.
REQ-009 SHALL have port wr_addr  input  3  target channel.
REQ-010 SHALL have port wr_data  input  16  pulse width in microseconds.
REQ-011 SHALL have port servo  output  8  per-channel servo pulse, registered.
REQ-012 SHALL have port frame_sync  output  1  one-clock pulse at each frame start, registered.
REQ-013 SHALL have port active_ch  output  3  channel owning the current slot, registered.

Function
REQ-014 SHALL share one microsecond timebase: divider counts 0..CLKS_PER_US-1; tick on the cycle divider = CLKS_PER_US-1.
REQ-015 SHALL divide a 20000 us frame into 8 slots of 2500 us; slot counter us_cnt counts 0..2499 on ticks; slot k belongs to channel k.
REQ-016 SHALL clamp each accepted wr_data into shadow[wr_addr]: <1000 -> 1000, >2000 -> 2000, else unchanged.
REQ-017 SHALL copy all 8 shadow values to active values only at a frame commit; mid-frame writes never alter a pulse in progress or later slots of that frame.
REQ-018 SHALL drive wr_ready low only on the commit cycle; a write presented then is held by the requester and accepted next cycle.
REQ-019 SHALL let the last accepted write to a channel within a frame win.
REQ-020 SHALL implement states IDLE, RUN, DRAIN.
REQ-021 IDLE: divider, us_cnt, active_ch held 0, servo = 0; when en = 1, next cycle enters RUN, performing a commit and pulsing frame_sync.
REQ-022 RUN: on tick with us_cnt = 2499, us_cnt -> 0 and active_ch increments; wrap 7 -> 0 is a frame boundary: commit, frame_sync = 1 for exactly one clock.
REQ-023 RUN: en = 0 moves to DRAIN; DRAIN completes the current slot then enters IDLE at the slot end; en re-asserted during DRAIN does not cancel it.
REQ-024 SHALL assert servo[k] iff state is RUN or DRAIN, active_ch = k, ch_en[k] = 1 and us_cnt < active[k]; all other servo bits 0; at most one bit high.
REQ-025 SHALL give each enabled pulse exactly active[k]*CLKS_PER_US clocks high, fixed one-clock output latency relative to counters.
REQ-026 ch_en[k] change SHALL take effect within one clock, including mid-pulse (truncation permitted).
REQ-027 SHALL produce frame_sync period of exactly 20000*CLKS_PER_US clocks in steady RUN.

Reset
REQ-028 rst = 1 SHALL immediately force: state IDLE, divider 0, us_cnt 0, active_ch 0, servo 0, frame_sync 0, wr_ready 1, all shadow and active values 1500.
REQ-029 rst asserted mid-pulse SHALL drop servo asynchronously; after release, operation restarts via IDLE per REQ-021.

Verification (bench SYS_CLK = 4000000, CLKS_PER_US = 4)
REQ-030 Reset then en = 1, ch_en = 8'hFF, no writes -> frame_sync after 1 clock; servo[0] high 6000 clocks, servo[1] rises 10000 clocks after servo[0] rise; frame_sync period 80000 clocks.
REQ-031 Write ch2 = 500, ch3 = 2600, ch4 = 1234 before first frame -> pulses 4000, 8000, 4936 clocks respectively.
REQ-032 Write ch0 = 1800 while servo[0] high in frame N -> frame N pulse stays 6000 clocks; frame N+1 pulse 7200 clocks.
REQ-033 wr_valid held on the commit cycle -> wr_ready = 0 that cycle, write accepted next cycle, applied next frame.
REQ-034 en = 0 midway through slot 5 -> slot 5 completes normally, IDLE at slot end, servo stays 0, no frame_sync; en = 1 -> restart at channel 0.
REQ-035 rst asserted while servo[1] high -> servo = 0 immediately; all channels return to 1500 us pulses after restart.
